// File: rtl/rv_pkg.sv
// Shared constants and enums for the register-file writeback scheduler.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int WAIT_W     = 4;

    typedef enum logic {A_PRIO, B_PRIO} wb_state_t;
    typedef enum logic {SRC_A, SRC_B} wb_src_t;
endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Writeback bus: A/B requests, scoreboard set/query and the register-file write port.
// Handshake: B is transferred in a cycle where b_valid & b_ready; B holds addr/data until then.
interface rf_wb_scheduler_if;
    import rv_pkg::*;

    logic                  a_valid;
    logic [REG_ADDR_W-1:0] a_addr;
    logic [XLEN-1:0]       a_data;
    logic                  a_stall;
    logic                  b_valid;
    logic [REG_ADDR_W-1:0] b_addr;
    logic [XLEN-1:0]       b_data;
    logic                  b_ready;
    logic                  sb_set;
    logic [REG_ADDR_W-1:0] sb_set_addr;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  wen_rf;
    logic [REG_ADDR_W-1:0] write_addr_rf;
    logic [XLEN-1:0]       write_data_rf;
    wb_state_t             dbg_state;
    logic [WAIT_W-1:0]     dbg_wait_cnt;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               sb_set, sb_set_addr, rs1_q, rs2_q,
        input  a_stall, b_ready, rs1_busy, rs2_busy,
               wen_rf, write_addr_rf, write_data_rf, dbg_state, dbg_wait_cnt
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               sb_set, sb_set_addr, rs1_q, rs2_q,
        output a_stall, b_ready, rs1_busy, rs2_busy,
               wen_rf, write_addr_rf, write_data_rf, dbg_state, dbg_wait_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy vector of registers awaiting a multi-cycle result; bit 0 is always clear.
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_q,
    input  logic [REG_ADDR_W-1:0] rs2_q,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    logic [NREG-1:0] busy_q, busy_d;

    // Set is applied after clear so a newly issued op wins a same-address collision.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1_q];
    assign rs2_busy = busy_q[rs2_q];
endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between pipeline (A) and multi-cycle (B) results.
module rf_wb_scheduler
    import rv_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32,
    parameter int NREG     = 32
) (
    input  logic             clk,
    input  logic             rst,
    rf_wb_scheduler_if.slave wb
);
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    wb_state_t             state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    wb_src_t               src_q, src_d;
    logic                  aw, bw, grant_a, grant_b;
    logic                  b_ready, a_stall;
    logic                  sb_rs1_busy, sb_rs2_busy;

    // Writes to x0 are not real requests; they are consumed without using the port.
    assign aw = wb.a_valid & (wb.a_addr != '0);
    assign bw = wb.b_valid & (wb.b_addr != '0);

    always_comb begin
        state_d = state_q;
        b_ready = 1'b0;
        a_stall = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            case (state_q)
                A_PRIO: begin
                    b_ready = wb.b_valid & (!aw | (wb.b_addr == '0));
                    grant_a = aw;
                    grant_b = bw & !aw;
                end
                B_PRIO: begin
                    b_ready = wb.b_valid;
                    a_stall = aw & bw;
                    grant_b = bw;
                    grant_a = aw & !bw;
                end
                default: ;
            endcase
        end

        // Count consecutive refusals of a real B request; anything else restarts it.
        if (bw && !b_ready) wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 1'b1;
        else                wait_d = '0;

        case (state_q)
            A_PRIO:  if (wait_d == MAX_W) state_d = B_PRIO;
            B_PRIO:  if (!wb.b_valid || b_ready) state_d = A_PRIO;
            default: state_d = A_PRIO;
        endcase

        wen_d   = grant_a | grant_b;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        src_d   = src_q;
        if (grant_b) begin
            waddr_d = wb.b_addr;
            wdata_d = wb.b_data;
            src_d   = SRC_B;
        end else if (grant_a) begin
            waddr_d = wb.a_addr;
            wdata_d = wb.a_data;
            src_d   = SRC_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= A_PRIO;
            wait_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            src_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            src_q   <= src_d;
        end
    end

    // Busy clears only once the B write has actually reached the register file.
    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (wb.sb_set),
        .set_addr (wb.sb_set_addr),
        .clr_en   (wen_q & (src_q == SRC_B)),
        .clr_addr (waddr_q),
        .rs1_q    (wb.rs1_q),
        .rs2_q    (wb.rs2_q),
        .rs1_busy (sb_rs1_busy),
        .rs2_busy (sb_rs2_busy)
    );

    assign wb.b_ready       = b_ready;
    assign wb.a_stall       = a_stall;
    assign wb.rs1_busy      = !rst & sb_rs1_busy;
    assign wb.rs2_busy      = !rst & sb_rs2_busy;
    assign wb.wen_rf        = wen_q;
    assign wb.write_addr_rf = waddr_q;
    assign wb.write_data_rf = wdata_q;
    assign wb.dbg_state     = state_q;
    assign wb.dbg_wait_cnt  = wait_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: vector table plus starvation, scoreboard and reset sequences.
module tb_rf_wb_scheduler;
    import rv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_wb_scheduler_if wbi();

    rf_wb_scheduler #(.MAX_WAIT(4), .DATA_W(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbi)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_comb(input string tag, input logic stall, input logic ready);
        chk({tag, ".a_stall"}, 32'(wbi.a_stall), 32'(stall));
        chk({tag, ".b_ready"}, 32'(wbi.b_ready), 32'(ready));
    endtask

    task automatic chk_wr(input string tag, input logic wen, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({tag, ".wen_rf"}, 32'(wbi.wen_rf), 32'(wen));
        chk({tag, ".write_addr_rf"}, 32'(wbi.write_addr_rf), 32'(addr));
        chk({tag, ".write_data_rf"}, wbi.write_data_rf, data);
    endtask

    task automatic chk_busy(input string tag, input logic b1, input logic b2);
        chk({tag, ".rs1_busy"}, 32'(wbi.rs1_busy), 32'(b1));
        chk({tag, ".rs2_busy"}, 32'(wbi.rs2_busy), 32'(b2));
    endtask

    // ---------------- driver ----------------
    // Inputs change at the falling edge; checks follow 1ns later, well clear of the rising edge.
    task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic ss, input logic [4:0] sa);
        @(negedge clk);
        rst             = r;
        wbi.a_valid     = av;
        wbi.a_addr      = aa;
        wbi.a_data      = ad;
        wbi.b_valid     = bv;
        wbi.b_addr      = ba;
        wbi.b_data      = bd;
        wbi.sb_set      = ss;
        wbi.sb_set_addr = sa;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_stall;
        logic        e_ready;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        checks = 0;
        errors = 0;
        rst             = 1'b1;
        wbi.a_valid     = 1'b1;
        wbi.a_addr      = 5'd5;
        wbi.a_data      = 32'hDEADBEEF;
        wbi.b_valid     = 1'b0;
        wbi.b_addr      = 5'd0;
        wbi.b_data      = 32'd0;
        wbi.sb_set      = 1'b0;
        wbi.sb_set_addr = 5'd0;
        wbi.rs1_q       = 5'd0;
        wbi.rs2_q       = 5'd0;

        // reset with A requesting, first A write, A/B conflict, x0 requests
        vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b1, 5'd7, 32'h11, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd7, 32'h11};
        vecs[7] = '{1'b0, 1'b1, 5'd4, 32'h44,       1'b1, 5'd0, 32'h99, 1'b0, 1'b1, 1'b0, 5'd7, 32'h11};
        vecs[8] = '{1'b0, 1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd4, 32'h44};
        vecs[9] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd4, 32'h44};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad,
                 vecs[i].bv, vecs[i].ba, vecs[i].bd, 1'b0, 5'd0);
            chk_comb($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_ready);
            chk_wr($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_data);
        end
        chk("vec_reset.rs1_busy", 32'(wbi.rs1_busy), 32'd0);

        // ---- starvation: A writes x6 every cycle, B waits with x9 ----
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 5'd6, 32'(32'hA0 + k), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
            chk_comb($sformatf("starve%0d", k), k == 5, k == 5);
            chk($sformatf("starve%0d.wait_cnt", k), 32'(wbi.dbg_wait_cnt), 32'(k - 1));
            if (k >= 2) chk_wr($sformatf("starve%0d", k), 1'b1, 5'd6, 32'(32'hA0 + k - 1));
        end
        chk("starve5.state", 32'(wbi.dbg_state), 32'(B_PRIO));
        step(1'b0, 1'b1, 5'd6, 32'hA5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk_comb("starve6", 1'b0, 1'b0);
        chk_wr("starve6", 1'b1, 5'd9, 32'h99);
        chk("starve6.state", 32'(wbi.dbg_state), 32'(A_PRIO));
        idle();
        chk_wr("starve7", 1'b1, 5'd6, 32'hA5);

        // ---- scoreboard: set x12, B writes x12, busy drops after the write cycle ----
        wbi.rs1_q = 5'd12;
        wbi.rs2_q = 5'd0;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        chk_busy("sb1", 1'b0, 1'b0);
        idle();
        chk_busy("sb2", 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
        chk_comb("sb3", 1'b0, 1'b1);
        chk_busy("sb3", 1'b1, 1'b0);
        idle();
        chk_wr("sb4", 1'b1, 5'd12, 32'hC0);
        chk_busy("sb4", 1'b1, 1'b0);
        idle();
        chk_busy("sb5", 1'b0, 1'b0);
        chk("sb5.wen_rf", 32'(wbi.wen_rf), 32'd0);

        // ---- collision: re-issue x12 on the edge that clears it; A writes never clear ----
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC1, 1'b0, 5'd0);
        chk_busy("col2", 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        chk_wr("col3", 1'b1, 5'd12, 32'hC1);
        idle();
        chk_busy("col4", 1'b1, 1'b0);
        step(1'b0, 1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk_busy("col5", 1'b1, 1'b0);
        idle();
        chk_wr("col6", 1'b1, 5'd12, 32'h12);
        idle();
        chk_busy("col7", 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC2, 1'b0, 5'd0);
        chk_comb("col8", 1'b0, 1'b1);
        idle();
        chk_busy("col9", 1'b1, 1'b0);
        idle();
        chk_busy("col10", 1'b0, 1'b0);

        // ---- reset mid-handshake: busy and refusal count both restart ----
        wbi.rs2_q = 5'd20;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
        for (int k = 1; k <= 2; k++) begin
            step(1'b0, 1'b1, 5'd6, 32'hB0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
            chk_comb($sformatf("rstmid%0d", k), 1'b0, 1'b0);
        end
        chk("rstmid2.rs2_busy", 32'(wbi.rs2_busy), 32'd1);
        step(1'b1, 1'b1, 5'd6, 32'hB0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
        chk_comb("rstmid3", 1'b0, 1'b0);
        chk("rstmid3.rs2_busy", 32'(wbi.rs2_busy), 32'd0);
        for (int k = 4; k <= 8; k++) begin
            step(1'b0, 1'b1, 5'd6, 32'hB0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
            chk_comb($sformatf("rstmid%0d", k), k == 8, k == 8);
        end
        chk("rstmid8.rs2_busy", 32'(wbi.rs2_busy), 32'd0);
        idle();
        chk_wr("rstmid9", 1'b1, 5'd9, 32'h9A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
